// File: rtl/seg7_scan_driver.sv
// Six-digit multiplexed seven-segment scanner with per-frame digit snapshot and anode blanking gaps.
// Optional build macro: LEADING_ZERO_BLANK_EN (dark hour-tens digit when it is zero).
module seg7_scan_driver #(
  parameter int DIV_CYCLES   = 5,
  parameter int BLANK_CYCLES = 1,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       i_en_disp,
  input  logic [3:0] i_sec_l,
  input  logic [3:0] i_sec_m,
  input  logic [3:0] i_min_l,
  input  logic [3:0] i_min_m,
  input  logic [3:0] i_hour_l,
  input  logic [3:0] i_hour_m,
  output logic [6:0] o_seg,
  output logic       o_dp,
  output logic [5:0] o_an,
  output logic       o_frame_done,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {ST_OFF = 2'd0, ST_BLANK = 2'd1, ST_DRIVE = 2'd2} state_t;

  localparam int CNT_W = $clog2(DIV_CYCLES + 1);
  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam state_t SLOT_START = (BLANK_CYCLES == 0) ? ST_DRIVE : ST_BLANK;
  localparam logic INV = (ACTIVE_LOW != 0);

  state_t           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0][3:0]  snap_q, snap_d;
  logic             snap_load;
  logic             lit;
  logic [5:0]       an_hi;
  logic [6:0]       seg_hi;
  logic             dp_hi;
  logic             fd_d;

  function automatic logic [6:0] decode(input logic [3:0] code);
    case (code)
      4'd0: decode = 7'h3F;
      4'd1: decode = 7'h06;
      4'd2: decode = 7'h5B;
      4'd3: decode = 7'h4F;
      4'd4: decode = 7'h66;
      4'd5: decode = 7'h6D;
      4'd6: decode = 7'h7D;
      4'd7: decode = 7'h07;
      4'd8: decode = 7'h7F;
      4'd9: decode = 7'h6F;
      default: decode = 7'h40;
    endcase
  endfunction

  assign dbg_state = state_q;

  // Next-state logic; the counter runs across the whole slot, blank cycles included.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    snap_load = 1'b0;
    if (!i_en_disp) begin
      state_d = ST_OFF;
      idx_d   = 3'd0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_OFF: begin
          snap_load = 1'b1;
          idx_d     = 3'd0;
          cnt_d     = '0;
          state_d   = SLOT_START;
        end
        ST_BLANK: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == BLANK_LAST) state_d = ST_DRIVE;
        end
        ST_DRIVE: begin
          if (cnt_q == DIV_LAST) begin
            cnt_d   = '0;
            state_d = SLOT_START;
            if (idx_q == 3'd5) begin
              idx_d     = 3'd0;
              snap_load = 1'b1;
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_OFF;
          idx_d   = 3'd0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are computed from the next state so they register in step with it.
  always_comb begin
    snap_d = snap_load ? {i_hour_m, i_hour_l, i_min_m, i_min_l, i_sec_m, i_sec_l} : snap_q;
    lit    = (state_d == ST_DRIVE);
`ifdef LEADING_ZERO_BLANK_EN
    if (idx_d == 3'd5 && snap_d[5] == 4'd0) lit = 1'b0;
`endif
    an_hi  = lit ? (6'b1 << idx_d) : 6'b0;
    seg_hi = lit ? decode(snap_d[idx_d]) : 7'b0;
    dp_hi  = lit && (idx_d == 3'd2 || idx_d == 3'd4);
    fd_d   = (state_d == ST_DRIVE) && (idx_d == 3'd5) && (cnt_d == DIV_LAST);
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_OFF;
      idx_q        <= 3'd0;
      cnt_q        <= '0;
      snap_q       <= '0;
      o_an         <= {6{INV}};
      o_seg        <= {7{INV}};
      o_dp         <= INV;
      o_frame_done <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      snap_q       <= snap_d;
      o_an         <= an_hi ^ {6{INV}};
      o_seg        <= seg_hi ^ {7{INV}};
      o_dp         <= dp_hi ^ INV;
      o_frame_done <= fd_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver (defaults: 5-cycle slots, 1 blank cycle, active-low),
// plus a second instance with no blanking checked for gap-free scanning.
module tb_seg7_scan_driver;

  logic       CLK;
  logic       rst_n;
  logic       en;
  logic [3:0] sec_l, sec_m, min_l, min_m, hour_l, hour_m;
  logic [6:0] o_seg, nb_seg;
  logic       o_dp, nb_dp;
  logic [5:0] o_an, nb_an;
  logic       o_fd, nb_fd;
  logic [1:0] dbg, nb_dbg;
  logic       en_seen;

  int checks = 0;
  int errors = 0;
  logic [14:0] exp_q[$];

  seg7_scan_driver dut (
    .CLK(CLK), .rst_n(rst_n), .i_en_disp(en),
    .i_sec_l(sec_l), .i_sec_m(sec_m), .i_min_l(min_l), .i_min_m(min_m),
    .i_hour_l(hour_l), .i_hour_m(hour_m),
    .o_seg(o_seg), .o_dp(o_dp), .o_an(o_an), .o_frame_done(o_fd), .dbg_state(dbg)
  );

  seg7_scan_driver #(.DIV_CYCLES(5), .BLANK_CYCLES(0), .ACTIVE_LOW(1)) dut_nb (
    .CLK(CLK), .rst_n(rst_n), .i_en_disp(en),
    .i_sec_l(sec_l), .i_sec_m(sec_m), .i_min_l(min_l), .i_min_m(min_m),
    .i_hour_l(hour_l), .i_hour_m(4'd1),
    .o_seg(nb_seg), .o_dp(nb_dp), .o_an(nb_an), .o_frame_done(nb_fd), .dbg_state(nb_dbg)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] seg_ref(input logic [3:0] c);
    case (c)
      4'd0: seg_ref = 7'h3F;  4'd1: seg_ref = 7'h06;
      4'd2: seg_ref = 7'h5B;  4'd3: seg_ref = 7'h4F;
      4'd4: seg_ref = 7'h66;  4'd5: seg_ref = 7'h6D;
      4'd6: seg_ref = 7'h7D;  4'd7: seg_ref = 7'h07;
      4'd8: seg_ref = 7'h7F;  4'd9: seg_ref = 7'h6F;
      default: seg_ref = 7'h40;
    endcase
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // one frame of expected {an, seg, dp, fd}; codes = {hour_m,hour_l,min_m,min_l,sec_m,sec_l}
  task automatic push_frame(input logic [23:0] codes);
    for (int c = 0; c < 30; c++) begin
      int d;
      logic lit;
      logic [3:0] code;
      logic [5:0] an;
      logic [6:0] seg;
      logic dp;
      d    = c / 5;
      lit  = (c % 5) != 0;
      code = codes[4*d +: 4];
`ifdef LEADING_ZERO_BLANK_EN
      if (d == 5 && code == 4'd0) lit = 1'b0;
`endif
      an  = lit ? ~(6'b1 << d) : 6'h3F;
      seg = lit ? ~seg_ref(code) : 7'h7F;
      dp  = (lit && (d == 2 || d == 4)) ? 1'b0 : 1'b1;
      exp_q.push_back({an, seg, dp, (c == 29)});
    end
  endtask

  // driver: advance n cycles comparing against the scoreboard; optional mid-frame sec_l change
  task automatic run_cycles(input int n, input int upd_at, input logic [3:0] upd_val);
    for (int c = 0; c < n; c++) begin
      logic [14:0] e;
      tick();
      if (exp_q.size() == 0) begin
        check($sformatf("queue_empty c%0d", c), 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("an c%0d", c),  {26'd0, o_an},  {26'd0, e[14:9]});
        check($sformatf("seg c%0d", c), {25'd0, o_seg}, {25'd0, e[8:2]});
        check($sformatf("dp c%0d", c),  {31'd0, o_dp},  {31'd0, e[1]});
        check($sformatf("fd c%0d", c),  {31'd0, o_fd},  {31'd0, e[0]});
      end
      if (c == upd_at) sec_l = upd_val;
    end
  endtask

  // continuous monitors: one anode at most, and no dark cycles without blanking
  always @(posedge CLK) en_seen <= en && rst_n;

  always @(negedge CLK) begin
    check("onehot_an", {31'd0, ($countones(~o_an) <= 1)}, 32'd1);
    check("onehot_nb", {31'd0, ($countones(~nb_an) <= 1)}, 32'd1);
    if (en_seen) check("nb_no_gap", {31'd0, (nb_an == 6'h3F)}, 32'd0);
  end

  initial begin
    rst_n = 1'b0; en = 1'b0;
    hour_m = 4'd1; hour_l = 4'd2; min_m = 4'd3; min_l = 4'd4; sec_m = 4'd5; sec_l = 4'd6;
    repeat (3) tick();
    check("rst_an",  {26'd0, o_an},  32'h3F);
    check("rst_seg", {25'd0, o_seg}, 32'h7F);
    check("rst_dp",  {31'd0, o_dp},  32'd1);
    check("rst_fd",  {31'd0, o_fd},  32'd0);
    check("rst_dbg", {30'd0, dbg},   32'd0);
    check("rst_nb",  {18'd0, nb_an, nb_seg, nb_dp, nb_fd, nb_dbg}, {18'd0, 6'h3F, 7'h7F, 1'b1, 1'b0, 2'd0});

    rst_n = 1'b1;
    tick();
    check("off_an",  {26'd0, o_an}, 32'h3F);
    check("off_dbg", {30'd0, dbg},  32'd0);

    // 12:34:56, then sec_l changes while digit 3 is lit in frame 2
    en = 1'b1;
    push_frame(24'h123456);
    run_cycles(30, -1, 4'd0);
    push_frame(24'h123456);
    run_cycles(30, 16, 4'd7);
    push_frame(24'h123457);
    run_cycles(30, -1, 4'd0);

    // drop enable on a lit digit-2 cycle for three cycles; new digits appear on restart
    push_frame(24'h123457);
    run_cycles(12, -1, 4'd0);
    exp_q.delete();
    en = 1'b0;
    hour_m = 4'd0;
    hour_l = 4'hB;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("gap_an%0d", i),  {26'd0, o_an},  32'h3F);
      check($sformatf("gap_seg%0d", i), {25'd0, o_seg}, 32'h7F);
      check($sformatf("gap_dp%0d", i),  {31'd0, o_dp},  32'd1);
      check($sformatf("gap_fd%0d", i),  {31'd0, o_fd},  32'd0);
      check($sformatf("gap_dbg%0d", i), {30'd0, dbg},   32'd0);
    end
    en = 1'b1;
    push_frame(24'h0B3457);
    run_cycles(30, -1, 4'd0);

    // asynchronous reset while a digit is being driven
    push_frame(24'h0B3457);
    run_cycles(3, -1, 4'd0);
    exp_q.delete();
    check("pre_rst_dbg", {30'd0, dbg}, 32'd2);
    rst_n = 1'b0;
    #1;
    check("arst_an",  {26'd0, o_an},  32'h3F);
    check("arst_seg", {25'd0, o_seg}, 32'h7F);
    check("arst_dp",  {31'd0, o_dp},  32'd1);
    check("arst_fd",  {31'd0, o_fd},  32'd0);
    check("arst_dbg", {30'd0, dbg},   32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
